imem_loader: RTL and testbench

- Boot-time writer for the instruction memory. It receives a big-endian byte stream over a valid/ready handshake and assembles the bytes into 32-bit MIPS instruction words.
- Each word is written to consecutive instruction-memory locations through a single write port.
- `cpu_hold` is asserted for the whole load so the processor stays stalled. It sits between the host/debug byte source and the instruction memory write port.

---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The slave modport is the loader's view; master is the host/memory side.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 5
);
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [31:0]       wd;

  modport slave (
    input  in_byte, in_valid,
    output in_ready, we, wa, wd
  );

  modport master (
    output in_byte, in_valid,
    input  in_ready, we, wa, wd
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: assembles a big-endian byte stream into
// 32-bit words, writes them to consecutive addresses, and stalls the CPU meanwhile.
module imem_loader #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              abort,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [31:0]       wd_q, wd_d;
  logic              we_q, we_d;
  logic              in_ready_q, in_ready_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       checksum_q, checksum_d;
  logic              accept;
  logic              num_ok;
  logic [31:0]       word_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      num_q      <= '0;
      word_q     <= '0;
      wa_q       <= '0;
      wd_q       <= '0;
      we_q       <= 1'b0;
      in_ready_q <= 1'b0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      num_q      <= num_d;
      word_q     <= word_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      we_q       <= we_d;
      in_ready_q <= in_ready_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      checksum_q <= checksum_d;
    end
  end

  assign accept    = (state_q == RECV) && bus.in_valid && in_ready_q;
  assign num_ok    = (num_words != '0) && (num_words <= CNT_W'(DEPTH));
  assign word_next = {word_q[23:0], bus.in_byte};

  // Next state plus registered outputs, which are derived from the next state.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    num_d      = num_q;
    word_d     = word_q;
    wa_d       = wa_q;
    wd_d       = wd_q;
    err_d      = err_q;
    checksum_d = checksum_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_ok) begin
            num_d      = num_words;
            err_d      = 1'b0;
            checksum_d = '0;
            wa_d       = '0;
            byte_cnt_d = '0;
            word_cnt_d = '0;
            state_d    = RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (accept) begin
          word_d     = word_next;
          byte_cnt_d = 2'(byte_cnt_q + 2'd1);
          if (byte_cnt_q == 2'd3) begin
            wd_d    = word_next;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        checksum_d = checksum_q ^ wd_q;
        word_cnt_d = CNT_W'(word_cnt_q + 1'b1);
        if (CNT_W'(word_cnt_q + 1'b1) == num_q) begin
          state_d = DONE;
        end else begin
          wa_d    = ADDR_W'(wa_q + 1'b1);
          state_d = RECV;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort drops any partial word; a word already on the port this cycle still lands.
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      err_d      = 1'b1;
      byte_cnt_d = '0;
      wa_d       = wa_q;
    end

    we_d       = (state_d == WRITE);
    in_ready_d = (state_d == RECV);
    cpu_hold_d = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  assign bus.in_ready = in_ready_q;
  assign bus.we       = we_q;
  assign bus.wa       = wa_q;
  assign bus.wd       = wd_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign checksum     = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal loads, gapped stream, bad starts,
// abort, ignored starts and mid-load reset.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] wa;
    logic [31:0]       wd;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic              abort;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [31:0]       checksum;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;
  int rdy_viol     = 0;
  wr_t wlog[$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_words (num_words),
    .abort     (abort),
    .bus       (bus.slave),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  // Record every memory write as the memory would capture it.
  always @(posedge clk) begin
    if (bus.we) begin
      wlog.push_back('{wa: bus.wa, wd: bus.wd});
      if (bus.in_ready) rdy_viol++;
    end
    if (done) done_cnt++;
  end

  task automatic do_start(input logic [ADDR_W:0] n, input logic ab);
    start = 1'b1; num_words = n; abort = ab;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles; returns at the negedge after acceptance.
  task automatic push_byte(input logic [7:0] b, input int gap);
    int n;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n >= 50) begin
      tests_failed++;
      $display("FAIL push_timeout: in_ready stayed %b, required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; num_words = '0;
    bus.in_byte = '0; bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus.we, bus.in_ready, cpu_hold, done, err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b, required 00000", {bus.we, bus.in_ready, cpu_hold, done, err});
    end
    tests_run++;
    if ({bus.wa, bus.wd, checksum} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: wa=%h wd=%h cs=%h, required all 0", bus.wa, bus.wd, checksum);
    end
  endtask

  task automatic test_basic();
    logic [7:0] bytes [8] = '{8'h00, 8'h00, 8'h0F, 8'hA0, 8'h00, 8'h00, 8'h1F, 8'h40};
    wlog.delete(); done_cnt = 0;
    do_start(6'd2, 1'b0);
    for (int i = 0; i < 8; i++) push_byte(bytes[i], 0);
    tests_run++;
    if ({bus.we, bus.in_ready, cpu_hold, bus.wa, bus.wd} !== {3'b101, 5'd1, 32'h00001F40}) begin
      tests_failed++;
      $display("FAIL basic_write2: we=%b rdy=%b hold=%b wa=%h wd=%h, required 1 0 1 01 00001f40",
               bus.we, bus.in_ready, cpu_hold, bus.wa, bus.wd);
    end
    @(negedge clk);
    tests_run++;
    if ({done, cpu_hold, bus.we} !== 3'b110) begin
      tests_failed++;
      $display("FAIL basic_done: done/hold/we=%b, required 110", {done, cpu_hold, bus.we});
    end
    @(negedge clk);
    tests_run++;
    if ({done, cpu_hold, checksum} !== {2'b00, 32'h000010E0}) begin
      tests_failed++;
      $display("FAIL basic_idle: done=%b hold=%b cs=%h, required 0 0 000010e0", done, cpu_hold, checksum);
    end
    tests_run++;
    if (wlog.size() != 2 || wlog[0] !== '{wa: 5'd0, wd: 32'h00000FA0} || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL basic_log: writes=%0d done_pulses=%0d, required 2 writes (first 0/00000fa0) 1 pulse",
               wlog.size(), done_cnt);
    end
  endtask

  task automatic test_full_gapped();
    logic [7:0]  b;
    logic [31:0] exp_wd;
    logic [31:0] exp_cs;
    wlog.delete(); rdy_viol = 0; exp_cs = '0;
    do_start(6'd32, 1'b0);
    for (int i = 0; i < 128; i++) begin
      b = 8'(i * 7 + 3);
      push_byte(b, int'($urandom_range(0, 2)));
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (wlog.size() != 32) begin
      tests_failed++;
      $display("FAIL full_count: got %0d writes, required 32", wlog.size());
    end
    for (int w = 0; w < 32 && w < wlog.size(); w++) begin
      exp_wd = {8'(w * 28 + 3), 8'(w * 28 + 10), 8'(w * 28 + 17), 8'(w * 28 + 24)};
      exp_cs = exp_cs ^ exp_wd;
      tests_run++;
      if (wlog[w] !== '{wa: 5'(w), wd: exp_wd}) begin
        tests_failed++;
        $display("FAIL full_word%0d: got %h/%h, required %h/%h", w, wlog[w].wa, wlog[w].wd, 5'(w), exp_wd);
      end
    end
    tests_run++;
    if (checksum !== exp_cs || rdy_viol != 0 || cpu_hold !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_end: cs=%h rdy_in_write=%0d hold=%b, required %h 0 0", checksum, rdy_viol, cpu_hold, exp_cs);
    end
  endtask

  task automatic test_bad_start();
    wlog.delete();
    do_start(6'd0, 1'b0);
    tests_run++;
    if ({err, cpu_hold, bus.in_ready} !== 3'b100) begin
      tests_failed++;
      $display("FAIL bad_zero: err/hold/rdy=%b, required 100", {err, cpu_hold, bus.in_ready});
    end
    do_start(6'd33, 1'b0);
    tests_run++;
    if ({err, cpu_hold, bus.in_ready} !== 3'b100) begin
      tests_failed++;
      $display("FAIL bad_33: err/hold/rdy=%b, required 100", {err, cpu_hold, bus.in_ready});
    end
    do_start(6'd1, 1'b0);
    tests_run++;
    if ({err, cpu_hold} !== 2'b01) begin
      tests_failed++;
      $display("FAIL bad_clear: err/hold=%b, required 01", {err, cpu_hold});
    end
    for (int i = 0; i < 4; i++) push_byte(8'(8'hC0 + i), 0);
    repeat (2) @(negedge clk);
    tests_run++;
    if (wlog.size() != 1 || wlog[0] !== '{wa: 5'd0, wd: 32'hC0C1C2C3}) begin
      tests_failed++;
      $display("FAIL bad_writes: got %0d writes, required 1 (0/c0c1c2c3)", wlog.size());
    end
  endtask

  task automatic test_abort();
    logic [7:0] bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    wlog.delete(); done_cnt = 0;
    do_start(6'd4, 1'b0);
    for (int i = 0; i < 6; i++) push_byte(bytes[i], 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if ({err, cpu_hold, bus.in_ready, bus.we} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL abort_state: err/hold/rdy/we=%b, required 1000", {err, cpu_hold, bus.in_ready, bus.we});
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (wlog.size() != 1 || wlog[0] !== '{wa: 5'd0, wd: 32'h11223344} || done_cnt != 0) begin
      tests_failed++;
      $display("FAIL abort_log: writes=%0d done_pulses=%0d, required 1 write (0/11223344) 0 pulses",
               wlog.size(), done_cnt);
    end
    do_start(6'd1, 1'b0);
    for (int i = 0; i < 4; i++) push_byte(8'(8'hAA + 8'h11 * i), 0);
    repeat (2) @(negedge clk);
    tests_run++;
    if (wlog.size() != 2 || wlog[1] !== '{wa: 5'd0, wd: 32'hAABBCCDD} || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_reload: writes=%0d err=%b, required 2 writes (second 0/aabbccdd) err 0",
               wlog.size(), err);
    end
  endtask

  task automatic test_ignored_start();
    wlog.delete(); done_cnt = 0;
    do_start(6'd2, 1'b0);
    push_byte(8'h01, 0);
    do_start(6'd5, 1'b0);
    for (int i = 1; i < 8; i++) push_byte(8'(i + 1), 0);
    @(negedge clk);
    start = 1'b1; num_words = 6'd3;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if ({cpu_hold, bus.in_ready} !== 2'b00 || wlog.size() != 2 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL ign_start: hold/rdy=%b writes=%0d done=%0d, required 00 2 1",
               {cpu_hold, bus.in_ready}, wlog.size(), done_cnt);
    end
    tests_run++;
    if (wlog.size() == 2 && wlog[1] !== '{wa: 5'd1, wd: 32'h05060708}) begin
      tests_failed++;
      $display("FAIL ign_word: got %h/%h, required 01/05060708", wlog[1].wa, wlog[1].wd);
    end
    do_start(6'd0, 1'b0);
    do_start(6'd1, 1'b1);
    tests_run++;
    if ({err, cpu_hold, bus.in_ready} !== 3'b011) begin
      tests_failed++;
      $display("FAIL start_abort: err/hold/rdy=%b, required 011", {err, cpu_hold, bus.in_ready});
    end
    for (int i = 0; i < 4; i++) push_byte(8'h5A, 0);
    repeat (2) @(negedge clk);
    tests_run++;
    if (wlog.size() != 3 || done_cnt != 2) begin
      tests_failed++;
      $display("FAIL start_abort_load: writes=%0d done=%0d, required 3 2", wlog.size(), done_cnt);
    end
  endtask

  task automatic test_mid_reset();
    wlog.delete();
    do_start(6'd5, 1'b0);
    for (int i = 0; i < 12; i++) push_byte(8'(8'h80 + i), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if ({bus.we, bus.in_ready, cpu_hold, done, err, bus.wa, bus.wd, checksum} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_vals: we=%b rdy=%b hold=%b done=%b err=%b wa=%h wd=%h cs=%h, required all 0",
               bus.we, bus.in_ready, cpu_hold, done, err, bus.wa, bus.wd, checksum);
    end
    bus.in_valid = 1'b1;
    repeat (10) @(negedge clk);
    bus.in_valid = 1'b0;
    tests_run++;
    if (wlog.size() != 3 || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_writes: writes=%0d rdy=%b, required 3 0", wlog.size(), bus.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_gapped();
    test_bad_start();
    test_abort();
    test_ignored_start();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
